// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and initiator.
//   i2c_state_e : 3-bit target FSM state encoding
//   I2cAck/Nack : SDA level of the ninth (acknowledge) bit
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StWaitStop
    } i2c_state_e;

    localparam logic I2cAck  = 1'b0;
    localparam logic I2cNack = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: bus front end for the I2C target.
// Synchronizes SCL/SDA into the clk domain, optionally glitch-filters them
// (macro I2C_SLAVE_GLITCH_FILTER_EN), and produces one-cycle event pulses.
// Ports:
//   clk, rst       : system clock, synchronous active-low reset
//   scl_i, sda_i   : raw bus pads
//   sda_o          : conditioned SDA level
//   scl_rise_o     : SCL rising edge pulse
//   scl_fall_o     : SCL falling edge pulse
//   start_o        : SDA fell while SCL high
//   stop_o         : SDA rose while SCL high
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_raw;
    logic                   sda_raw;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Reset to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_raw = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic [CntW-1:0] scl_cnt_q;
    logic [CntW-1:0] sda_cnt_q;
    logic            scl_filt_q;
    logic            sda_filt_q;

    // A line follows its synchronized input only after FILTER_LEN
    // consecutive samples that disagree with the current filtered level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            if (scl_raw == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CntW'(FILTER_LEN - 1)) begin
                scl_filt_q <= scl_raw;
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CntW'(1);
            end
            if (sda_raw == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CntW'(FILTER_LEN - 1)) begin
                sda_filt_q <= sda_raw;
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CntW'(1);
            end
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign scl_lvl = scl_raw;
    assign sda_lvl = sda_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    assign sda_o      = sda_lvl;
    assign scl_rise_o = scl_lvl & ~scl_prev_q;
    assign scl_fall_o = ~scl_lvl & scl_prev_q;
    // SCL must be high on both samples so a simultaneous SCL/SDA change is ignored.
    assign start_o    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
    assign stop_o     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: single-address I2C target (7-bit addressing, no clock stretching).
// Optional glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
// Ports:
//   clk, rst   : system clock (>= 20x SCL), synchronous active-low reset
//   SCL        : bus clock input
//   SDA        : open-drain bus data, driven 0 or released
//   tx_data    : byte returned on read, latched at each tx_req
//   rx_data    : last byte written by the master
//   rx_valid   : one-cycle strobe, rx_data updated
//   tx_req     : one-cycle strobe, tx_data latched, next byte may be presented
//   busy       : address matched, until STOP or repeated START
//   ack_error  : one-cycle strobe, master NACKed a read byte
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'b0001111,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       ack_error
);

    logic sda_in;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_bus_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       ack_error_q, ack_error_d;
    logic       busy_q, busy_d;
    logic       sda_low_q, sda_low_d;
    logic       rw_q, rw_d;
    logic       ack_seen_q, ack_seen_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q, sda_in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        ack_error_d = 1'b0;
        busy_d      = busy_q;
        sda_low_d   = sda_low_q;
        rw_d        = rw_q;
        ack_seen_d  = ack_seen_q;

        if (stop) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            // shift_q holds the 7 address bits; sda_in is R/W.
                            if (shift_q == SLAVE_ADDR) begin
                                state_d = StAddrAck;
                                rw_d    = sda_in;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end
                end
                StAddrAck, StWriteAck: begin
                    // First fall (end of bit 8) starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else if (state_q == StAddrAck && rw_q) begin
                            tx_shift_d = tx_data;
                            tx_req_d   = 1'b1;
                            sda_low_d  = ~tx_data[7];
                            bit_cnt_d  = '0;
                            state_d    = StRead;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            state_d    = StWriteAck;
                        end
                    end
                end
                StRead: begin
                    // bit_cnt counts bits already on the bus beyond bit 7.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_low_d  = 1'b0;
                            bit_cnt_d  = '0;
                            ack_seen_d = 1'b0;
                            state_d    = StReadAck;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], tx_shift_q[7]};
                            sda_low_d  = ~tx_shift_q[6];
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StReadAck: begin
                    if (scl_rise) begin
                        if (sda_in == I2cAck) begin
                            ack_seen_d = 1'b1;
                        end else begin
                            ack_error_d = 1'b1;
                            state_d     = StWaitStop;
                        end
                    end else if (scl_fall && ack_seen_q) begin
                        tx_shift_d = tx_data;
                        tx_req_d   = 1'b1;
                        sda_low_d  = ~tx_data[7];
                        bit_cnt_d  = '0;
                        state_d    = StRead;
                    end
                end
                default: begin
                    // StIdle and StWaitStop wait for a bus condition only.
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            ack_error_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_low_q   <= 1'b0;
            rw_q        <= 1'b0;
            ack_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            ack_error_q <= ack_error_d;
            busy_q      <= busy_d;
            sda_low_q   <= sda_low_d;
            rw_q        <= rw_d;
            ack_seen_q  <= ack_seen_d;
        end
    end

    assign SDA       = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign ack_error = ack_error_q;

endmodule
